// File: rtl/vproc_xreg_result_rob_if.sv
// Handshake bundle between the dispatcher, the execution units and the result
// stage on one side and the x-register result release buffer on the other.
//
// Signal groups:
//   alloc_*          : dispatcher allocates an entry in program order
//   wb_*             : execution unit writes back a 32-bit result by instruction ID
//   result_xreg_*    : in-order release of completed results (valid/ready)
//
// Modports:
//   master : the surrounding pipeline (drives requests, accepts results)
//   slave  : the release buffer itself
interface vproc_xreg_result_rob_if #(
    parameter int unsigned XIF_ID_W = 3
);
    logic                alloc_valid_i;
    logic                alloc_ready_o;
    logic [XIF_ID_W-1:0] alloc_id_i;
    logic [4:0]          alloc_addr_i;

    logic                wb_valid_i;
    logic [XIF_ID_W-1:0] wb_id_i;
    logic [31:0]         wb_data_i;
    logic                wb_err_o;

    logic                result_xreg_valid_o;
    logic                result_xreg_ready_i;
    logic [XIF_ID_W-1:0] result_xreg_id_o;
    logic [4:0]          result_xreg_addr_o;
    logic [31:0]         result_xreg_data_o;

    modport master (
        output alloc_valid_i, alloc_id_i, alloc_addr_i,
        output wb_valid_i, wb_id_i, wb_data_i,
        output result_xreg_ready_i,
        input  alloc_ready_o, wb_err_o,
        input  result_xreg_valid_o, result_xreg_id_o, result_xreg_addr_o, result_xreg_data_o
    );

    modport slave (
        input  alloc_valid_i, alloc_id_i, alloc_addr_i,
        input  wb_valid_i, wb_id_i, wb_data_i,
        input  result_xreg_ready_i,
        output alloc_ready_o, wb_err_o,
        output result_xreg_valid_o, result_xreg_id_o, result_xreg_addr_o, result_xreg_data_o
    );
endinterface

// File: rtl/vproc_xreg_result_rob.sv
// In-order release buffer for vector instructions that produce an x-register
// result (vmv.x.s, vcpop.m, vfirst.m, ...). Entries are allocated in program
// order, completed out of order by ID-tagged writebacks, and released strictly
// in allocation order.
//
// Ports:
//   clk_i        : clock
//   async_rst_ni : asynchronous active-low reset
//   sync_rst_ni  : synchronous active-low reset, same effect as flush_i
//   flush_i      : discard all entries (overrides alloc/wb/pop in that cycle)
//   xreg_if      : alloc / writeback / result handshakes (slave side)
//   count_o      : number of occupied entries
//   empty_o      : no entry occupied
module vproc_xreg_result_rob #(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned DEPTH          = 4,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    async_rst_ni,
    input  logic                    sync_rst_ni,
    input  logic                    flush_i,
    vproc_xreg_result_rob_if.slave  xreg_if,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Per-entry status bits (reset) and payload storage (not reset).
    logic [DEPTH-1:0]    valid_reg, valid_next;
    logic [DEPTH-1:0]    done_reg,  done_next;
    logic [XIF_ID_W-1:0] id_mem   [DEPTH];
    logic [4:0]          addr_mem [DEPTH];
    logic [31:0]         data_mem [DEPTH];

    logic [PTR_W-1:0]    head_reg,  head_next;
    logic [PTR_W-1:0]    tail_reg,  tail_next;
    logic [CNT_W-1:0]    count_reg, count_next;

    logic                discard;
    logic                alloc_ready;
    logic                alloc_fire;
    logic                head_ready;
    logic                result_valid;
    logic                pop_fire;
    logic [DEPTH-1:0]    wb_hit;
    logic [DEPTH-1:0]    entry_alloc;
    logic [DEPTH-1:0]    entry_pop;

    // A flush and a synchronous reset are the same operation.
    assign discard     = flush_i | ~sync_rst_ni;

    // Based on the registered count only: a pop in this cycle does not
    // free a slot for an allocation in the same cycle.
    assign alloc_ready = (count_reg < CNT_W'(DEPTH));
    assign alloc_fire  = xreg_if.alloc_valid_i & alloc_ready & ~discard;

    assign head_ready   = valid_reg[head_reg] & done_reg[head_reg];
    assign result_valid = head_ready & ~discard;
    assign pop_fire     = result_valid & xreg_if.result_xreg_ready_i;

    // Per-entry matching and status update. Writebacks only match entries
    // that were already valid at the start of the cycle, so an entry being
    // allocated right now cannot be hit.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wb_hit[gi]      = xreg_if.wb_valid_i & valid_reg[gi] & ~done_reg[gi]
                                   & (id_mem[gi] == xreg_if.wb_id_i);
            assign entry_alloc[gi] = alloc_fire & (tail_reg == PTR_W'(gi));
            assign entry_pop[gi]   = pop_fire   & (head_reg == PTR_W'(gi));
            assign valid_next[gi]  = ~discard & ~entry_pop[gi] & (valid_reg[gi] | entry_alloc[gi]);
            assign done_next[gi]   = ~discard & ~entry_pop[gi] & (done_reg[gi]  | wb_hit[gi]);
        end
    endgenerate

    // Pointer and occupancy next state.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (discard) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (alloc_fire) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            if (pop_fire) begin
                head_next = head_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(alloc_fire) - CNT_W'(pop_fire);
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            valid_reg <= '0;
            done_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            done_reg  <= done_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload storage, intentionally without reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_alloc[i]) begin
                id_mem[i]   <= xreg_if.alloc_id_i;
                addr_mem[i] <= xreg_if.alloc_addr_i;
            end
            if (wb_hit[i] & ~discard) begin
                data_mem[i] <= xreg_if.wb_data_i;
            end
        end
    end

    // Result port: payload of the head entry, stable until popped because
    // head and its data only change on a pop or a flush.
    always_comb begin
        xreg_if.result_xreg_valid_o = result_valid;
        if (result_valid) begin
            xreg_if.result_xreg_id_o   = id_mem[head_reg];
            xreg_if.result_xreg_addr_o = addr_mem[head_reg];
            xreg_if.result_xreg_data_o = data_mem[head_reg];
        end else if (DONT_CARE_ZERO) begin
            xreg_if.result_xreg_id_o   = '0;
            xreg_if.result_xreg_addr_o = '0;
            xreg_if.result_xreg_data_o = '0;
        end else begin
            xreg_if.result_xreg_id_o   = 'x;
            xreg_if.result_xreg_addr_o = 'x;
            xreg_if.result_xreg_data_o = 'x;
        end
    end

    assign xreg_if.alloc_ready_o = alloc_ready;
    assign xreg_if.wb_err_o      = xreg_if.wb_valid_i & ~(|wb_hit) & ~discard;
    assign count_o               = count_reg;
    assign empty_o               = (count_reg == '0);

    // IDs of pending entries must be unique, so a writeback hits at most one.
    assert property (@(posedge clk_i) disable iff (!async_rst_ni) $onehot0(wb_hit));

endmodule
